// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ifu_pkg
//  Purpose  : Shared widths, PC constants and the prefetch entry type used by
//             the instruction fetch unit and its prefetch queue.
//  Revision : 1.0  initial release
// ============================================================================
package ifu_pkg;

    localparam int          IFU_WORD_W     = 32;
    localparam logic [31:0] IFU_PC_INC     = 32'd4;
    localparam logic [31:0] IFU_ALIGN_MASK = 32'hFFFF_FFFC;

    // One prefetched word together with the byte address it came from.
    typedef struct packed {
        logic [IFU_WORD_W-1:0] pc;
        logic [IFU_WORD_W-1:0] instr;
    } fetch_entry_t;

endpackage : ifu_pkg
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Synchronous FIFO of fetch_entry_t used as the prefetch buffer.
//             Flush empties the queue and takes priority over push and pop.
//             A push while full is accepted only if a pop happens in the same
//             cycle, so occupancy never exceeds DEPTH.
//  Ports    : clk, rst      clock and synchronous active-high reset
//             push, pop     enqueue / dequeue requests
//             flush         discard all entries
//             full, empty   occupancy status
//             head          entry at the read pointer (meaningful when !empty)
//  Revision : 1.0  initial release
// ============================================================================
module fetch_queue
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    logic               do_pop;
    logic               do_push;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the head is only consumed while non-empty.
    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule : fetch_queue
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch_unit
//  Purpose  : Requester side of the instruction-memory read port. Holds the
//             PC, drives the word-aligned fetch address to a combinational
//             ROM, buffers returned words in a prefetch queue and presents them
//             to decode over a valid/ready handshake. Execute-stage redirects
//             flush the queue and reload the PC.
//  Ports    : Clk, Rst           clock, synchronous active-high reset
//             Address            fetch byte address (= PC)
//             Instruction        ROM data for Address, same cycle
//             InstrOut, PCOut    head word and its byte address
//             InstrValid         head is valid
//             InstrReady         decode accepts the head
//             Redirect           taken branch/jump pulse
//             RedirectPC         redirect target (low two bits dropped)
//             FetchCount         words pushed (only with IFU_PERF_CNT_EN)
//  Options  : IFU_PERF_CNT_EN    adds the FetchCount port and its counter
//  Revision : 1.0  initial release
// ============================================================================
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    output logic [31:0] Address,
    input  logic [31:0] Instruction,
    output logic [31:0] InstrOut,
    output logic [31:0] PCOut,
    output logic        InstrValid,
`ifdef IFU_PERF_CNT_EN
    output logic [31:0] FetchCount,
`endif
    input  logic        InstrReady,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC
);

    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    fetch_entry_t last_q;
    fetch_entry_t last_d;

    logic         q_full;
    logic         q_empty;
    fetch_entry_t q_head;
    fetch_entry_t q_push_data;
    logic         accept;
    logic         fe;

    assign Address     = pc_q;
    assign InstrValid  = !q_empty;
    assign accept      = InstrValid && InstrReady;
    assign fe          = !Redirect && (!q_full || accept);
    assign q_push_data = '{pc: pc_q, instr: Instruction};

    // While empty, the outputs hold the most recently accepted entry rather
    // than whatever stale word sits at the read pointer.
    assign InstrOut = q_empty ? last_q.instr : q_head.instr;
    assign PCOut    = q_empty ? last_q.pc    : q_head.pc;

    always_comb begin
        pc_d   = pc_q;
        last_d = last_q;
        if (Redirect) begin
            pc_d = RedirectPC & IFU_ALIGN_MASK;
        end else if (fe) begin
            pc_d = pc_q + IFU_PC_INC;
        end
        // An entry accepted in the redirect cycle still counts as delivered.
        if (accept) begin
            last_d = q_head;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc_q   <= RESET_PC;
            last_q <= '0;
        end else begin
            pc_q   <= pc_d;
            last_q <= last_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_fetch_queue (
        .clk       (Clk),
        .rst       (Rst),
        .push      (fe),
        .pop       (accept),
        .flush     (Redirect),
        .push_data (q_push_data),
        .full      (q_full),
        .empty     (q_empty),
        .head      (q_head)
    );

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;

    // Counts pushes; deliberately untouched by redirects.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            fetch_cnt_q <= '0;
        end else if (fe) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end
    end

    assign FetchCount = fetch_cnt_q;
`endif

endmodule : instruction_fetch_unit
`default_nettype wire
